// File: rtl/branch_pc_ctrl_if.sv
// Request/response bundle for the branch next-PC controller.
// start is a request pulse taken only while the controller is idle (busy=0); done is a one-cycle response pulse.
interface branch_pc_ctrl_if #(
    parameter int PC_W  = 16,
    parameter int OFF_W = 9
);
    logic             start;
    logic [PC_W-1:0]  pc_in;
    logic             is_branch;
    logic             is_reg;
    logic [2:0]       cond;
    logic [2:0]       flags;
    logic [OFF_W-1:0] imm;
    logic [PC_W-1:0]  reg_target;
    logic             busy;
    logic             done;
    logic [PC_W-1:0]  pc_next;
    logic             taken;
    logic             trap;

    modport master (
        output start, pc_in, is_branch, is_reg, cond, flags, imm, reg_target,
        input  busy, done, pc_next, taken, trap
    );

    modport slave (
        input  start, pc_in, is_branch, is_reg, cond, flags, imm, reg_target,
        output busy, done, pc_next, taken, trap
    );
endinterface

// File: rtl/branch_pc_ctrl.sv
// Multi-cycle next-PC controller sharing one ripple adder between PC+2 and the branch target.
// Optional macro BRANCH_TGT_TRAP_EN: a signed-overflowing B target suppresses the branch and raises trap.
module branch_pc_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module branch_pc_ctrl #(
    parameter int PC_W  = 16,
    parameter int OFF_W = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_pc_ctrl_if.slave       bus,
    output logic [1:0]            state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INC  = 2'd1,
        S_TGT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc_lat;
    logic [PC_W-1:0]   rt_lat;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_next_q;
    logic              is_branch_lat;
    logic              is_reg_lat;
    logic [2:0]        cond_lat;
    logic [2:0]        flags_lat;
    logic [OFF_W-1:0]  imm_lat;
    logic              busy_q;
    logic              done_q;
    logic              taken_q;

    logic [PC_W-1:0]   add_a;
    logic [PC_W-1:0]   add_b;
    logic [PC_W-1:0]   add_sum;
    logic [PC_W:0]     carry;
    logic [PC_W-1:0]   off_ext;
    logic              cond_ok;
    logic              br_taken;
    logic              unused_carry;

    // Word offset: sign-extend then shift left by one (bit 0 always zero).
    assign off_ext = {{(PC_W-OFF_W-1){imm_lat[OFF_W-1]}}, imm_lat, 1'b0};

    always_comb begin
        add_a = pc_lat;
        add_b = PC_W'(2);
        if (state == S_TGT) begin
            add_a = pc_inc;
            add_b = off_ext;
        end
    end

    assign carry[0] = 1'b0;
    generate
        for (genvar i = 0; i < PC_W; i++) begin : g_rca
            branch_pc_ctrl_fa u_fa (
                .a    (add_a[i]),
                .b    (add_b[i]),
                .cin  (carry[i]),
                .s    (add_sum[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate
    assign unused_carry = carry[PC_W];

    // Flags are packed {Z,V,N}.
    always_comb begin
        cond_ok = 1'b0;
        case (cond_lat)
            3'b000: cond_ok = ~flags_lat[2];
            3'b001: cond_ok = flags_lat[2];
            3'b010: cond_ok = ~flags_lat[2] & ~flags_lat[0];
            3'b011: cond_ok = flags_lat[0];
            3'b100: cond_ok = flags_lat[2] | (~flags_lat[2] & ~flags_lat[0]);
            3'b101: cond_ok = flags_lat[0] | flags_lat[2];
            3'b110: cond_ok = flags_lat[1];
            default: cond_ok = 1'b1;
        endcase
    end
    assign br_taken = is_branch_lat & cond_ok;

`ifdef BRANCH_TGT_TRAP_EN
    logic ovf;
    logic tgt_ovf;
    assign ovf = (add_a[PC_W-1] == add_b[PC_W-1]) && (add_sum[PC_W-1] != add_a[PC_W-1]);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            pc_lat        <= '0;
            rt_lat        <= '0;
            pc_inc        <= '0;
            pc_next_q     <= '0;
            is_branch_lat <= 1'b0;
            is_reg_lat    <= 1'b0;
            cond_lat      <= '0;
            flags_lat     <= '0;
            imm_lat       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            taken_q       <= 1'b0;
`ifdef BRANCH_TGT_TRAP_EN
            tgt_ovf       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef BRANCH_TGT_TRAP_EN
            tgt_ovf <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        pc_lat        <= bus.pc_in;
                        rt_lat        <= bus.reg_target;
                        is_branch_lat <= bus.is_branch;
                        is_reg_lat    <= bus.is_reg;
                        cond_lat      <= bus.cond;
                        flags_lat     <= bus.flags;
                        imm_lat       <= bus.imm;
                        busy_q        <= 1'b1;
                        state         <= S_INC;
                    end
                end
                S_INC: begin
                    pc_inc <= add_sum;
                    if (br_taken && !is_reg_lat) begin
                        state <= S_TGT;
                    end else begin
                        pc_next_q <= br_taken ? rt_lat : add_sum;
                        taken_q   <= br_taken;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_TGT: begin
                    // The target registers straight into pc_next; no separate holding copy is needed.
`ifdef BRANCH_TGT_TRAP_EN
                    tgt_ovf   <= ovf;
                    pc_next_q <= ovf ? pc_inc : add_sum;
                    taken_q   <= ~ovf;
`else
                    pc_next_q <= add_sum;
                    taken_q   <= 1'b1;
`endif
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state     <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pc_next = pc_next_q;
    assign bus.taken   = taken_q;
`ifdef BRANCH_TGT_TRAP_EN
    assign bus.trap    = tgt_ovf;
`else
    assign bus.trap    = 1'b0;
`endif
    assign state_dbg   = state;
endmodule

// File: doc/branch_pc_ctrl.md
Name: branch_pc_ctrl

Overview:
Multi-cycle next-PC controller for the branch path. It owns one shared 16-bit ripple adder, built from 1-bit full-adder cells, and time-multiplexes it.
- Step 1: PC+2.
- Step 2: (PC+2) + (sign-extended offset << 1), only when a PC-relative branch is taken.
It evaluates the branch condition against the latched flags and returns the resolved next PC to fetch with a start/done handshake.

Parameters:
- PC_W, 16, PC/adder width.
- OFF_W, 9, branch offset immediate width (signed).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only when busy=0.
- pc_in  in  PC_W  PC of the branch instruction.
- is_branch  in  1  1 = B/BR instruction; 0 = plain increment.
- is_reg  in  1  1 = BR (register target); 0 = B (PC-relative).
- cond  in  3  condition code.
- flags  in  3  {Z,V,N} from the flag register.
- imm  in  OFF_W  signed word offset.
- reg_target  in  PC_W  register target for BR.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; pc_next/taken valid.
- pc_next  out  PC_W  resolved next PC.
- taken  out  1  branch taken.
- trap  out  1  target overflow trap (see Optional Feature).

Behaviour:
Reset:
- rst is synchronous, active-high, and wins over everything, including mid-operation.
- On reset: state=IDLE; busy=0, done=0, taken=0, trap=0, pc_next=16'h0000; internal registers cleared.

Handshake:
- start is sampled only in IDLE.
- On acceptance, pc_in, is_branch, is_reg, cond, flags, imm and reg_target are latched; later input changes are ignored.
- start while busy=1 is ignored (not queued).

FSM states: IDLE, INC, TGT, DONE.
- IDLE -> INC on accepted start. busy=1 from the next cycle.
- INC: adder A=pc_lat, B=16'h0002, cin=0; result registered into pc_inc. Condition is evaluated here.
  - If taken and is_reg=0 -> TGT.
  - Else -> DONE.
- TGT: adder A=pc_inc, B=sext(imm)<<1 (imm[8] replicated to bits 15:10, bit0=0); result registered into pc_tgt. -> DONE.
- DONE: done=1 for exactly one cycle; busy deasserted in this same cycle. -> IDLE.

pc_next selection (updated on entry to DONE, held until the next DONE or reset):
- not taken: pc_inc
- taken, BR: reg_target
- taken, B: pc_tgt

Latency, with start at cycle 0: done at cycle 2 for not-taken, BR and non-branch; cycle 3 for taken B. A new start is accepted in the cycle after done.

Condition table (taken only if is_branch=1):
- 000 Z=0
- 001 Z=1
- 010 Z=0 & N=0
- 011 N=1
- 100 Z=1 | (Z=0 & N=0)
- 101 N=1 | Z=1
- 110 V=1
- 111 always

Arithmetic:
- Plain 16-bit modulo addition.
- Adder overflow is the signed rule: operands of equal sign with a result of differing sign. It is registered in TGT as tgt_ovf.
- PC+2 wrap (0xFFFE -> 0x0000) is legal and never traps.

Optional Feature:
Macro: BRANCH_TGT_TRAP_EN
- Defined: if tgt_ovf=1 in TGT, the branch is suppressed. In DONE: pc_next=pc_inc, taken=0, trap=1 (one cycle, coincident with done).
- Undefined: the target wraps silently (pc_next=pc_tgt, taken=1); trap is tied 0; tgt_ovf logic is absent.

Test Plan:
- Reset mid-TGT: pc_in=16'h0100, B cond=111, imm=9'h004, assert rst during TGT -> next cycle busy=0, done=0, pc_next=0; no done pulse follows.
- Non-branch: is_branch=0, pc_in=16'h1234 -> done at cycle 2, pc_next=16'h1236, taken=0.
- Taken B: cond=001, flags Z=1, pc_in=16'h0100, imm=9'h1FE (-2) -> done at cycle 3, pc_next=16'h00FE, taken=1.
- Not-taken B: cond=010, Z=0, N=1, pc_in=16'h0200 -> done at cycle 2, pc_next=16'h0202; TGT never entered.
- BR with start spam: cond=110, V=1, reg_target=16'hBEEF, start held high for 4 cycles -> exactly one done at cycle 2, pc_next=16'hBEEF; second accept in the cycle after done.
- Overflow: pc_in=16'h7FF0, imm=9'h0FF, cond=111 -> with BRANCH_TGT_TRAP_EN: pc_next=16'h7FF2, trap=1, taken=0; without it: pc_next=16'h81F0, taken=1, trap=0.
